// File: rtl/ifu_pipelined.sv
// ifu_pipelined: pipelined instruction fetch unit with credit-limited issue, PC/insn queue, branch stall and redirect drop counter.
// Optional IFU_JAL_FOLLOW_EN: follow JAL targets locally instead of stalling for the branch unit.
package ifu_pkg;
  typedef enum logic [2:0] {ALU, MUL, DIV, LSU, BU} e_functional_unit;
endpackage

module ifu_pipelined
  import ifu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 64,
  parameter int QUEUE_DEPTH = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic instruction_poll_i,
  input  logic bcast_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] bcast_value_i,
  input  e_functional_unit bcast_rs_i,
  output logic fetch_ready_o,
  output logic [31:0] fetch_insn_o,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc_o,
  output logic [ADDRESS_WIDTH-1:0] imem_load_addr_o,
  output logic imem_load_en_o,
  input  logic [31:0] imem_load_insn_i,
  input  logic imem_load_busy_i,
  input  logic imem_load_rdy_i
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(QUEUE_DEPTH);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] MAX_O = IW'(MAX_OUTSTANDING);
  localparam logic [CW+1:0] QD = (CW+2)'(QUEUE_DEPTH);
  logic [AW-1:0] fetch_pc, resp_pc, target, jimm, jal_tgt;
  logic [IW-1:0] inflight, inflight_nx, drop;
  logic [CW:0] count;
  logic [CW-1:0] head, tail;
  logic [AW+31:0] mem [QUEUE_DEPTH];
  logic stall, redirect, issue, push, pop, is_br, follow;
  logic [6:0] opcode;
  assign redirect = bcast_valid_i && bcast_rs_i == BU;
  assign target = bcast_value_i & ~AW'(3);
  assign opcode = imem_load_insn_i[6:0];
  assign jimm = {{(AW-21){imem_load_insn_i[31]}}, imem_load_insn_i[31], imem_load_insn_i[19:12],
                 imem_load_insn_i[20], imem_load_insn_i[30:21], 1'b0};
  assign jal_tgt = resp_pc + jimm;
`ifdef IFU_JAL_FOLLOW_EN
  assign follow = opcode == 7'b1101111;
  assign is_br = opcode == 7'b1100011 || opcode == 7'b1100111;
`else
  assign follow = 1'b0;
  assign is_br = opcode == 7'b1100011 || opcode == 7'b1100111 || opcode == 7'b1101111;
`endif
  // credit check reserves a queue slot for every request already in flight
  assign issue = rst_n && !stall && !redirect && !imem_load_busy_i && inflight < MAX_O &&
                 (CW+2)'(inflight) + (CW+2)'(count) < QD;
  assign inflight_nx = inflight + IW'(issue) - IW'(imem_load_rdy_i);
  assign push = imem_load_rdy_i && !redirect && drop == '0;
  assign pop = instruction_poll_i && fetch_ready_o;
  assign fetch_ready_o = count != '0 && !redirect;
  assign {fetch_pc_o, fetch_insn_o} = mem[head];
  assign imem_load_addr_o = fetch_pc;
  assign imem_load_en_o = issue;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
      stall <= 1'b0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      inflight <= inflight_nx;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc <= target;
        stall <= 1'b0;
        drop <= inflight_nx;
        count <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        count <= count + (CW+1)'(push) - (CW+1)'(pop);
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        if (imem_load_rdy_i && drop != '0) drop <= drop - 1'b1;
        if (issue) fetch_pc <= fetch_pc + AW'(4);
        if (push) resp_pc <= resp_pc + AW'(4);
        if (push && is_br) begin
          stall <= 1'b1;
          drop <= inflight_nx;
        end
        if (push && follow) begin
          fetch_pc <= jal_tgt;
          resp_pc <= jal_tgt;
          drop <= inflight_nx;
        end
      end
    end
  end
  always_ff @(posedge clk) if (push) mem[tail] <= {resp_pc, imem_load_insn_i};
endmodule

// File: tb/tb_ifu_pipelined.sv
// tb_ifu_pipelined: scoreboard bench with a fixed-latency in-order imem model and epoch-based stale tracking.
module tb_ifu_pipelined;
  import ifu_pkg::*;
  localparam int LAT = 3;
  localparam logic [63:0] NONE = '1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instruction_poll_i = 1'b0, bcast_valid_i = 1'b0;
  logic [63:0] bcast_value_i = '0;
  e_functional_unit bcast_rs_i = ALU;
  logic fetch_ready_o, imem_load_en_o;
  logic [31:0] fetch_insn_o, imem_load_insn_i = '0;
  logic [63:0] fetch_pc_o, imem_load_addr_o;
  logic imem_load_busy_i = 1'b0, imem_load_rdy_i = 1'b0;
  typedef struct {longint unsigned due; logic [63:0] addr; int ep;} req_t;
  typedef struct {logic [63:0] pc; logic [31:0] insn;} ent_t;
  req_t pend[$];
  ent_t sb[$];
  int checks = 0, passed = 0, issued = 0, pops = 0, epoch = 0;
  longint unsigned cyc = 0;
  logic stalled = 1'b0, busy = 1'b0, got_first = 1'b0;
  logic [63:0] exp_fetch = '0, first_pc = '0, prev_pc = '0, pc_after_jal = '0;
  logic [63:0] br_addr = NONE, jal_addr = NONE;

  ifu_pipelined dut (
    .clk(clk), .rst_n(rst_n), .instruction_poll_i(instruction_poll_i),
    .bcast_valid_i(bcast_valid_i), .bcast_value_i(bcast_value_i), .bcast_rs_i(bcast_rs_i),
    .fetch_ready_o(fetch_ready_o), .fetch_insn_o(fetch_insn_o), .fetch_pc_o(fetch_pc_o),
    .imem_load_addr_o(imem_load_addr_o), .imem_load_en_o(imem_load_en_o),
    .imem_load_insn_i(imem_load_insn_i), .imem_load_busy_i(imem_load_busy_i),
    .imem_load_rdy_i(imem_load_rdy_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] insn_at(input logic [63:0] a);
    if (a == br_addr) return 32'h0000_0063;
    if (a == jal_addr) return 32'h0200_006F;
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    imem_load_rdy_i = 1'b0;
    instruction_poll_i = 1'b0;
    bcast_valid_i = 1'b0;
    #1;
    check("rst_ready", {63'd0, fetch_ready_o}, 64'd0);
    check("rst_en", {63'd0, imem_load_en_o}, 64'd0);
    check("rst_addr", imem_load_addr_o, 64'd0);
    pend.delete();
    sb.delete();
    epoch++;
    stalled = 1'b0;
    exp_fetch = '0;
    issued = 0;
    pops = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic poll_v, input logic redir, input logic [63:0] tgt);
    logic rdy;
    ent_t e;
    req_t r;
    rdy = pend.size() > 0 && pend[0].due <= cyc;
    imem_load_rdy_i = rdy;
    imem_load_insn_i = rdy ? insn_at(pend[0].addr) : 32'd0;
    imem_load_busy_i = busy;
    instruction_poll_i = poll_v;
    bcast_valid_i = redir;
    bcast_rs_i = BU;
    bcast_value_i = tgt;
    #1;
    check("ready", {63'd0, fetch_ready_o}, {63'd0, sb.size() > 0 && !redir});
    if (fetch_ready_o && poll_v && !redir && sb.size() > 0) begin
      e = sb.pop_front();
      check("pc", fetch_pc_o, e.pc);
      check("insn", {32'd0, fetch_insn_o}, {32'd0, e.insn});
      pops++;
      if (prev_pc == jal_addr) pc_after_jal = e.pc;
      prev_pc = e.pc;
      if (!got_first) begin
        got_first = 1'b1;
        first_pc = e.pc;
      end
    end
    if (stalled || redir) check("no_issue", {63'd0, imem_load_en_o}, 64'd0);
    if (imem_load_en_o) begin
      check("addr", imem_load_addr_o, exp_fetch);
      pend.push_back('{cyc + LAT, exp_fetch, epoch});
      check("outstanding", {63'd0, pend.size() <= 4}, 64'd1);
      exp_fetch += 64'd4;
      issued++;
    end
    if (rdy) begin
      r = pend.pop_front();
      if (!redir && r.ep == epoch) begin
        sb.push_back('{r.addr, insn_at(r.addr)});
        if (r.addr == br_addr) begin
          stalled = 1'b1;
          epoch++;
        end
        if (r.addr == jal_addr) begin
`ifdef IFU_JAL_FOLLOW_EN
          exp_fetch = r.addr + 64'h20;
`else
          stalled = 1'b1;
`endif
          epoch++;
        end
      end
    end
    if (redir) begin
      sb.delete();
      epoch++;
      stalled = 1'b0;
      exp_fetch = tgt & ~64'h3;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    // sequential fetch with a decoder that never polls: credit stops issue at 8
    repeat (20) cycle(1'b0, 1'b0, '0);
    check("issued8", 64'(issued), 64'd8);
    check("idle_en", {63'd0, imem_load_en_o}, 64'd0);
    got_first = 1'b0;
    repeat (14) cycle(1'b1, 1'b0, '0);
    check("first_seq", first_pc, 64'd0);
    check("pops8", {63'd0, pops >= 8}, 64'd1);
    // branch at 0x8 stalls, later responses dropped, BU redirect to 0x100
    br_addr = 64'h8;
    do_reset();
    repeat (14) cycle(1'b1, 1'b0, '0);
    check("br_pops", 64'(pops), 64'd3);
    got_first = 1'b0;
    cycle(1'b0, 1'b1, 64'h100);
    repeat (10) cycle(1'b1, 1'b0, '0);
    check("br_first", first_pc, 64'h100);
    br_addr = NONE;
    // redirect coincides with a response and a poll
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, '0);
    got_first = 1'b0;
    cycle(1'b1, 1'b1, 64'h43);
    repeat (10) cycle(1'b1, 1'b0, '0);
    check("redir_first", first_pc, 64'h40);
    // JAL at 0x10 with +0x20
    jal_addr = 64'h10;
    pc_after_jal = '0;
    do_reset();
    repeat (14) cycle(1'b1, 1'b0, '0);
`ifndef IFU_JAL_FOLLOW_EN
    check("jal_stall_en", {63'd0, imem_load_en_o}, 64'd0);
    cycle(1'b1, 1'b1, 64'h30);
`endif
    repeat (8) cycle(1'b1, 1'b0, '0);
    check("jal_next", pc_after_jal, 64'h30);
    jal_addr = NONE;
    // PC wraps modulo 2^64
    do_reset();
    got_first = 1'b0;
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (10) cycle(1'b1, 1'b0, '0);
    check("wrap_first", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_pops", {63'd0, pops >= 3}, 64'd1);
    // asynchronous reset with 2 in flight and 5 queued
    do_reset();
    repeat (7) cycle(1'b0, 1'b0, '0);
    busy = 1'b1;
    cycle(1'b0, 1'b0, '0);
    check("pre_rst_queued", 64'(sb.size()), 64'd5);
    check("pre_rst_inflight", 64'(pend.size()), 64'd2);
    busy = 1'b0;
    do_reset();
    got_first = 1'b0;
    repeat (8) cycle(1'b1, 1'b0, '0);
    check("rst_first", first_pc, 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
